// File: rtl/alu_issue_stage.sv
// alu_issue_stage: RV32I execute-issue register producing alu_control, operands and class flags.
// Define ALU_ISSUE_PERF_EN to add the issue_count/stall_count performance counters.
module alu_issue_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           in_instr,
  input  logic [DATA_WIDTH-1:0] in_pc,
  input  logic [DATA_WIDTH-1:0] in_rs1_data,
  input  logic [DATA_WIDTH-1:0] in_rs2_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [3:0]            alu_control,
  output logic [DATA_WIDTH-1:0] op_a,
  output logic [DATA_WIDTH-1:0] op_b,
  output logic [DATA_WIDTH-1:0] store_data,
  output logic [DATA_WIDTH-1:0] imm,
  output logic [REG_ADDR_W-1:0] rd,
  output logic                  reg_write,
  output logic                  is_branch,
  output logic                  is_jump,
  output logic                  is_load,
  output logic                  is_store,
  output logic                  illegal
`ifdef ALU_ISSUE_PERF_EN
  ,
  output logic [31:0]           issue_count,
  output logic [31:0]           stall_count
`endif
);
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] F7_BASE    = 7'b0000000;
  localparam logic [6:0] F7_ALT     = 7'b0100000;

  function automatic logic [DATA_WIDTH-1:0] sext(input logic [31:0] v);
    return DATA_WIDTH'($signed(v));
  endfunction

  logic [6:0]            w_opc, w_f7;
  logic [2:0]            w_f3;
  logic [31:0]           w_i_imm, w_s_imm, w_b_imm, w_u_imm, w_j_imm;
  logic [3:0]            w_base, w_alu;
  logic [DATA_WIDTH-1:0] w_a, w_b, w_imm, w_sd;
  logic [REG_ADDR_W-1:0] w_rd;
  logic                  w_rw, w_br, w_jmp, w_ld, w_st, w_ill, w_xfer;

  logic                  r_valid;
  logic [3:0]            r_alu;
  logic [DATA_WIDTH-1:0] r_a, r_b, r_imm, r_sd;
  logic [REG_ADDR_W-1:0] r_rd;
  logic                  r_rw, r_br, r_jmp, r_ld, r_st, r_ill;

  assign w_opc   = in_instr[6:0];
  assign w_f3    = in_instr[14:12];
  assign w_f7    = in_instr[31:25];
  assign w_rd    = REG_ADDR_W'(in_instr[11:7]);
  assign w_i_imm = {{20{in_instr[31]}}, in_instr[31:20]};
  assign w_s_imm = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
  assign w_b_imm = {{20{in_instr[31]}}, in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
  assign w_u_imm = {in_instr[31:12], 12'b0};
  assign w_j_imm = {{12{in_instr[31]}}, in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};

  assign in_ready = !r_valid || out_ready;
  assign w_xfer   = in_valid && in_ready;

  // funct3 to ALU code for the non-alternate (funct7=0) arithmetic ops
  always_comb begin
    case (w_f3)
      3'b000:  w_base = 4'b0000;
      3'b001:  w_base = 4'b0101;
      3'b010:  w_base = 4'b1000;
      3'b011:  w_base = 4'b1001;
      3'b100:  w_base = 4'b0010;
      3'b101:  w_base = 4'b0110;
      3'b110:  w_base = 4'b0011;
      default: w_base = 4'b0100;
    endcase
  end

  always_comb begin
    w_alu = 4'b0000;
    w_a   = '0;
    w_b   = '0;
    w_imm = '0;
    w_sd  = '0;
    w_rw  = 1'b0;
    w_br  = 1'b0;
    w_jmp = 1'b0;
    w_ld  = 1'b0;
    w_st  = 1'b0;
    w_ill = 1'b0;
    case (w_opc)
      OPC_OP: begin
        w_ill = !(w_f7 == F7_BASE || (w_f7 == F7_ALT && (w_f3 == 3'b000 || w_f3 == 3'b101)));
        w_alu = (w_f7 == F7_ALT) ? ((w_f3 == 3'b000) ? 4'b0001 : 4'b0111) : w_base;
        w_a   = in_rs1_data;
        w_b   = in_rs2_data;
        w_rw  = 1'b1;
      end
      OPC_IMM: begin
        w_ill = (w_f3 == 3'b001 && w_f7 != F7_BASE) ||
                (w_f3 == 3'b101 && w_f7 != F7_BASE && w_f7 != F7_ALT);
        w_alu = (w_f3 == 3'b101 && w_f7 == F7_ALT) ? 4'b0111 : w_base;
        w_a   = in_rs1_data;
        w_b   = sext(w_i_imm);
        w_imm = sext(w_i_imm);
        w_rw  = 1'b1;
      end
      OPC_LOAD: begin
        w_a   = in_rs1_data;
        w_b   = sext(w_i_imm);
        w_imm = sext(w_i_imm);
        w_rw  = 1'b1;
        w_ld  = 1'b1;
      end
      OPC_JALR: begin
        w_ill = w_f3 != 3'b000;
        w_a   = in_rs1_data;
        w_b   = sext(w_i_imm);
        w_imm = sext(w_i_imm);
        w_rw  = 1'b1;
        w_jmp = 1'b1;
      end
      OPC_STORE: begin
        w_a   = in_rs1_data;
        w_b   = sext(w_s_imm);
        w_imm = sext(w_s_imm);
        w_sd  = in_rs2_data;
        w_st  = 1'b1;
      end
      OPC_LUI: begin
        w_b   = sext(w_u_imm);
        w_imm = sext(w_u_imm);
        w_rw  = 1'b1;
      end
      OPC_AUIPC: begin
        w_a   = in_pc;
        w_b   = sext(w_u_imm);
        w_imm = sext(w_u_imm);
        w_rw  = 1'b1;
      end
      OPC_JAL: begin
        w_a   = in_pc;
        w_b   = sext(w_j_imm);
        w_imm = sext(w_j_imm);
        w_rw  = 1'b1;
        w_jmp = 1'b1;
      end
      OPC_BRANCH: begin
        w_ill = w_f3 == 3'b010 || w_f3 == 3'b011;
        w_alu = w_f3[2] ? {2'b11, w_f3[1:0]} : {3'b101, w_f3[0]};
        w_a   = in_rs1_data;
        w_b   = in_rs2_data;
        w_imm = sext(w_b_imm);
        w_br  = 1'b1;
      end
      default: w_ill = 1'b1;
    endcase
    // illegal encodings issue as a harmless ADD 0,0 with every side effect suppressed
    if (w_ill) begin
      w_alu = 4'b0000;
      w_a   = '0;
      w_b   = '0;
      w_imm = '0;
      w_sd  = '0;
      w_rw  = 1'b0;
      w_br  = 1'b0;
      w_jmp = 1'b0;
      w_ld  = 1'b0;
      w_st  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_alu   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_imm   <= '0;
      r_sd    <= '0;
      r_rd    <= '0;
      r_rw    <= 1'b0;
      r_br    <= 1'b0;
      r_jmp   <= 1'b0;
      r_ld    <= 1'b0;
      r_st    <= 1'b0;
      r_ill   <= 1'b0;
    end else if (flush) begin
      r_valid <= 1'b0;
      r_rw    <= 1'b0;
      r_br    <= 1'b0;
      r_jmp   <= 1'b0;
      r_ld    <= 1'b0;
      r_st    <= 1'b0;
      r_ill   <= 1'b0;
    end else if (w_xfer) begin
      r_valid <= 1'b1;
      r_alu   <= w_alu;
      r_a     <= w_a;
      r_b     <= w_b;
      r_imm   <= w_imm;
      r_sd    <= w_sd;
      r_rd    <= w_rd;
      r_rw    <= w_rw && (w_rd != '0);
      r_br    <= w_br;
      r_jmp   <= w_jmp;
      r_ld    <= w_ld;
      r_st    <= w_st;
      r_ill   <= w_ill;
    end else if (out_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign out_valid   = r_valid;
  assign alu_control = r_alu;
  assign op_a        = r_a;
  assign op_b        = r_b;
  assign imm         = r_imm;
  assign store_data  = r_sd;
  assign rd          = r_rd;
  assign reg_write   = r_rw;
  assign is_branch   = r_br;
  assign is_jump     = r_jmp;
  assign is_load     = r_ld;
  assign is_store    = r_st;
  assign illegal     = r_ill;

`ifdef ALU_ISSUE_PERF_EN
  logic [31:0] r_issue_cnt, r_stall_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_issue_cnt <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (r_valid && out_ready) r_issue_cnt <= r_issue_cnt + 32'd1;
      if (r_valid && !out_ready) r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign issue_count = r_issue_cnt;
  assign stall_count = r_stall_cnt;
`endif
endmodule

// File: tb/tb_alu_issue_stage.sv
// tb_alu_issue_stage: directed RV32I vectors with hand-computed expectations for alu_issue_stage.
module tb_alu_issue_stage;
  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic        reg_write, is_branch, is_jump, is_load, is_store, illegal;
  logic [31:0] in_instr, in_pc, in_rs1_data, in_rs2_data, op_a, op_b, store_data, imm;
  logic [3:0]  alu_control;
  logic [4:0]  rd;
`ifdef ALU_ISSUE_PERF_EN
  logic [31:0] issue_count, stall_count;
`endif
  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  alu_issue_stage dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
    .out_valid(out_valid), .out_ready(out_ready), .alu_control(alu_control),
    .op_a(op_a), .op_b(op_b), .store_data(store_data), .imm(imm), .rd(rd),
    .reg_write(reg_write), .is_branch(is_branch), .is_jump(is_jump),
    .is_load(is_load), .is_store(is_store), .illegal(illegal)
`ifdef ALU_ISSUE_PERF_EN
    , .issue_count(issue_count), .stall_count(stall_count)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic drive(input logic [31:0] instr, input logic [31:0] pc, input logic [31:0] a, input logic [31:0] b);
    in_valid = 1'b1;
    in_instr = instr;
    in_pc = pc;
    in_rs1_data = a;
    in_rs2_data = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    in_instr = '0;
    in_pc = '0;
    in_rs1_data = '0;
    in_rs2_data = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", out_valid, 0);
    check("rst_alu", alu_control, 0);
    check("rst_opa", op_a, 0);
    check("rst_opb", op_b, 0);
    check("rst_imm", imm, 0);
    check("rst_rd", rd, 0);
    check("rst_flags", {reg_write, is_branch, is_jump, is_load, is_store, illegal}, 0);
    check("rst_in_ready", in_ready, 1);
    rst = 1'b0;

    drive(32'h40208033, 32'h0, 32'd10, 32'd3);
    check("sub_valid", out_valid, 1);
    check("sub_alu", alu_control, 4'b0001);
    check("sub_opa", op_a, 10);
    check("sub_opb", op_b, 3);
    check("sub_rw", reg_write, 0);
    check("sub_ill", illegal, 0);

    drive(32'hFFF00293, 32'h0, 32'd0, 32'd0);
    check("addi_alu", alu_control, 4'b0000);
    check("addi_opb", op_b, 32'hFFFFFFFF);
    check("addi_rd", rd, 5);
    check("addi_rw", reg_write, 1);

    drive(32'hFE20DCE3, 32'h40, 32'd7, 32'd9);
    check("bge_alu", alu_control, 4'b1101);
    check("bge_imm", imm, 32'hFFFFFFF8);
    check("bge_br", is_branch, 1);
    check("bge_rw", reg_write, 0);
    check("bge_ops", {op_a[15:0], op_b[15:0]}, {16'd7, 16'd9});

    drive(32'h0040A183, 32'h0, 32'h1000, 32'd0);
    check("lw_ld", is_load, 1);
    check("lw_opa", op_a, 32'h1000);
    check("lw_opb", op_b, 4);
    check("lw_rw", reg_write, 1);

    drive(32'h0020A423, 32'h0, 32'h2000, 32'hCAFEF00D);
    check("sw_st", is_store, 1);
    check("sw_opb", op_b, 8);
    check("sw_sd", store_data, 32'hCAFEF00D);
    check("sw_rw", reg_write, 0);

    drive(32'h123453B7, 32'h0, 32'h55, 32'h0);
    check("lui_opa", op_a, 0);
    check("lui_opb", op_b, 32'h12345000);
    check("lui_rw", reg_write, 1);

    drive(32'h00001097, 32'h00000200, 32'h0, 32'h0);
    check("auipc_opa", op_a, 32'h200);
    check("auipc_opb", op_b, 32'h1000);

    drive(32'h010000EF, 32'h00000300, 32'h0, 32'h0);
    check("jal_opa", op_a, 32'h300);
    check("jal_opb", op_b, 16);
    check("jal_jmp", is_jump, 1);
    check("jal_rw", reg_write, 1);

    @(posedge clk);
    #1;
    check("drain_valid", out_valid, 0);

    out_ready = 1'b0;
    drive(32'h002081B3, 32'h0, 32'd1, 32'd2);
    in_valid = 1'b1;
    in_instr = 32'h0020C233;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("stall_in_ready", in_ready, 0);
      check("stall_rd", rd, 3);
      check("stall_alu", alu_control, 4'b0000);
    end
`ifdef ALU_ISSUE_PERF_EN
    check("stall_count", stall_count, 3);
`endif
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("release_valid", out_valid, 1);
    check("release_alu", alu_control, 4'b0010);
    check("release_rd", rd, 4);
    @(posedge clk);
    #1;

    out_ready = 1'b0;
    drive(32'h0040A183, 32'h0, 32'h10, 32'h0);
    check("hold_ld", is_load, 1);
    in_valid = 1'b1;
    in_instr = 32'h123453B7;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    in_valid = 1'b0;
    check("flush_valid", out_valid, 0);
    check("flush_flags", {reg_write, is_load, illegal}, 0);
    @(posedge clk);
    #1;
    check("flush_nocapture", out_valid, 0);
    out_ready = 1'b1;
    in_valid = 1'b1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    in_valid = 1'b0;
    check("flush_idle_valid", out_valid, 0);
`ifdef ALU_ISSUE_PERF_EN
    check("issue_count", issue_count, 10);
    check("stall_count_flush", stall_count, 4);
`endif

    drive(32'h0000107F, 32'h100, 32'd5, 32'd6);
    check("unk_valid", out_valid, 1);
    check("unk_ill", illegal, 1);
    check("unk_alu", alu_control, 0);
    check("unk_rw", reg_write, 0);
    check("unk_ops", op_a | op_b, 0);

    drive(32'h0230D093, 32'h0, 32'd5, 32'd0);
    check("srai_bad_ill", illegal, 1);
    check("srai_bad_alu", alu_control, 0);
    check("srai_bad_rw", reg_write, 0);

    drive(32'h4030D093, 32'h0, 32'd5, 32'd0);
    check("srai_alu", alu_control, 4'b0111);
    check("srai_opb", op_b, 32'h403);
    check("srai_ill", illegal, 0);

    drive(32'h022081B3, 32'h0, 32'd1, 32'd2);
    check("op_f7_ill", illegal, 1);

    drive(32'h0020A063, 32'h0, 32'd1, 32'd2);
    check("br_f3_ill", illegal, 1);
    check("br_f3_br", is_branch, 0);

    @(posedge clk);
    #1;
    check("end_valid", out_valid, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
